bcd_entry: RTL and testbench
============================

Name: bcd_entry

Overview:
- Keypad-side operand entry stage for the calculator.
- Accumulates decimal key presses into a 3-digit BCD value with sign, and exposes the live value for the display.
- On ENTER, latches the operand and hands it downstream, via a valid/ready handshake, to the BCD-to-binary converter that consumes three BCD digits plus a negative flag.

Parameters:
- DIGITS, 3, number of BCD digits held; the downstream converter is sized for 3.
- AUTO_CLEAR, 1, 1 = live entry clears after a successful handoff; 0 = live value is retained.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle key event strobe
- key_code  in  4  0x0-0x9 digit, 0xA SIGN, 0xB BKSP, 0xC CLEAR, 0xD ENTER, 0xE-0xF reserved
- key_ready  out  1  high when a key event will be accepted
- live_bcds  out  4*DIGITS  live entry value; digit i at [4i+3:4i], digit 0 = units
- live_negative  out  1  live sign
- digit_count  out  2  significant digits entered (0..DIGITS)
- overflow  out  1  sticky; set when a digit is rejected because the entry is full
- op_bcds  out  4*DIGITS  latched operand, same packing as live_bcds
- op_negative  out  1  latched sign
- op_valid  out  1  operand available
- op_ready  in  1  downstream accepts operand

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs 0, except key_ready = 1.
  - State EMPTY.
  - Reset during HOLD drops op_valid immediately; no handoff occurs.
- States:
  - EMPTY: digit_count = 0.
  - ENTRY: digit_count >= 1.
  - HOLD: op_valid = 1.
- key_ready = 1 in EMPTY and ENTRY, 0 in HOLD. A key event is accepted only when key_valid & key_ready; a key_valid while key_ready is low is dropped, not queued.
- Accepted keys update registers on the same clock edge; outputs reflect the change the following cycle (1-cycle latency).
- Digit d:
  - digit_count < DIGITS: live_bcds <= {live_bcds[4*DIGITS-5:0], d}.
    - If d = 0 and count = 0: value stays 0, count stays 0 (no leading zeros).
    - Otherwise count increments and state goes to ENTRY.
  - digit_count = DIGITS: value unchanged, overflow <= 1.
- SIGN: live_negative toggles in EMPTY or ENTRY. A negative zero is permitted and is passed through as entered.
- BKSP:
  - live_bcds <= {4'h0, live_bcds[4*DIGITS-1:4]}.
  - count decrements; when it reaches 0, state goes to EMPTY.
  - Clears overflow.
  - BKSP in EMPTY is a no-op, and sign is preserved.
- CLEAR: live value, sign, count and overflow go to 0; state goes to EMPTY.
- ENTER (EMPTY or ENTRY):
  - op_bcds <= live_bcds and op_negative <= live_negative; op_valid goes to 1; state goes to HOLD.
  - ENTER in EMPTY sends operand 0.
- Reserved codes: ignored, no state change.
- HOLD:
  - op_bcds and op_negative are stable while op_valid is high.
  - op_valid & op_ready on an edge completes the handoff: op_valid goes to 0 on the next cycle.
  - AUTO_CLEAR = 1: live value, sign, count and overflow are cleared and the state goes to EMPTY.
  - AUTO_CLEAR = 0: live registers are kept and the state returns to ENTRY, or to EMPTY if count = 0.
  - op_ready with op_valid low has no effect.
- Every live_bcds nibble is always 0-9; no invalid BCD is ever produced.
- Downstream binary range is 0..999. This stage never exceeds it.

Decomposition:
- Package calc_pkg:
  - Key code localparams: KEY_SIGN, KEY_BKSP, KEY_CLEAR, KEY_ENTER.
  - State enum: EMPTY, ENTRY, HOLD.
  - Constants: DIGITS_DEFAULT = 3 and BCD_W = 4.
- Optional sub-module bcd_shift_reg: the DIGITS-nibble left/right shift register with load-zero, which holds the digit datapath separately from the FSM.

Test Plan:
1. Reset, then keys 1, 2, 3 -> live_bcds = 0x123, digit_count = 3, overflow = 0. Then key 4 -> value still 0x123, overflow = 1.
2. Keys 0, 0, 7 -> live_bcds = 0x007, count = 1. Then BKSP -> 0x000, count = 0, state EMPTY. Then BKSP again -> no change.
3. Keys 4, 5, SIGN, ENTER with op_ready held 0 for 5 cycles -> op_valid = 1, op_bcds = 0x045, op_negative = 1 and stable throughout; key_ready = 0; a digit key during HOLD is dropped. Then op_ready = 1 -> op_valid goes low next cycle; live value cleared (AUTO_CLEAR = 1).
4. ENTER in EMPTY -> op_bcds = 0x000, op_negative = 0, op_valid = 1.
5. Keys 9, 9, 9, ENTER, then rst_n pulsed low mid-HOLD -> op_valid goes to 0 asynchronously; all outputs at reset values; no handoff seen downstream.
6. AUTO_CLEAR = 0: keys 6, 2, ENTER, then op_ready = 1 -> live_bcds stays 0x062, state ENTRY. Then key 1 -> 0x621.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad/operand path: key codes, entry FSM states, BCD sizing.
// Pure declarations; no logic, no latency.
package calc_pkg;

   localparam int DIGITS_DEFAULT = 3;
   localparam int BCD_W          = 4;

   localparam logic [3:0] KEY_SIGN  = 4'hA;
   localparam logic [3:0] KEY_BKSP  = 4'hB;
   localparam logic [3:0] KEY_CLEAR = 4'hC;
   localparam logic [3:0] KEY_ENTER = 4'hD;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ENTRY = 2'd1,
      HOLD  = 2'd2
   } state_e;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/bcd_shift_reg.sv
// DIGITS-nibble BCD shift register: shift-left-in a digit, shift-right-out (backspace), or load zero.
// Registered, 1-cycle latency; no flow control, the owner decides when to shift.
module bcd_shift_reg
   import calc_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      shl,
   input  logic                      shr,
   input  logic [BCD_W-1:0]          digit_in,
   output logic [BCD_W*DIGITS-1:0]   bcds
);

   logic [BCD_W*DIGITS-1:0] bcds_q;
   logic [BCD_W*DIGITS-1:0] bcds_d;

   // Clear wins over shifts so a reset-style load never mixes with an edit.
   always_comb begin
      bcds_d = bcds_q;
      if (clr) begin
         bcds_d = '0;
      end else if (shl) begin
         bcds_d = {bcds_q[BCD_W*(DIGITS-1)-1:0], digit_in};
      end else if (shr) begin
         bcds_d = {{BCD_W{1'b0}}, bcds_q[BCD_W*DIGITS-1:BCD_W]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcds_q <= '0;
      end else begin
         bcds_q <= bcds_d;
      end
   end

   assign bcds = bcds_q;

endmodule

// File: rtl/bcd_entry.sv
// Keypad operand entry: accumulates signed 3-digit BCD, hands it downstream on ENTER via valid/ready.
// Keys take effect 1 cycle later; key_ready drops while an operand is held until op_ready accepts it.
module bcd_entry
   import calc_pkg::*;
#(
   parameter int DIGITS     = DIGITS_DEFAULT,
   parameter bit AUTO_CLEAR = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      key_valid,
   input  logic [3:0]                key_code,
   output logic                      key_ready,
   output logic [BCD_W*DIGITS-1:0]   live_bcds,
   output logic                      live_negative,
   output logic [1:0]                digit_count,
   output logic                      overflow,
   output logic [BCD_W*DIGITS-1:0]   op_bcds,
   output logic                      op_negative,
   output logic                      op_valid,
   input  logic                      op_ready
);

   state_e                  state_q, state_d;
   logic [1:0]              count_q, count_d;
   logic                    neg_q, neg_d;
   logic                    ovf_q, ovf_d;
   logic [BCD_W*DIGITS-1:0] op_bcds_q, op_bcds_d;
   logic                    op_neg_q, op_neg_d;
   logic                    op_vld_q, op_vld_d;
   logic                    sr_clr, sr_shl, sr_shr;
   logic                    key_acc;
   logic [BCD_W*DIGITS-1:0] live_bcds_w;

   bcd_shift_reg #(.DIGITS(DIGITS)) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (sr_clr),
      .shl      (sr_shl),
      .shr      (sr_shr),
      .digit_in (key_code),
      .bcds     (live_bcds_w)
   );

   assign key_acc = key_valid && (state_q != HOLD);

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      neg_d     = neg_q;
      ovf_d     = ovf_q;
      op_bcds_d = op_bcds_q;
      op_neg_d  = op_neg_q;
      op_vld_d  = op_vld_q;
      sr_clr    = 1'b0;
      sr_shl    = 1'b0;
      sr_shr    = 1'b0;

      if (state_q == HOLD) begin
         if (op_ready) begin
            op_vld_d = 1'b0;
            if (AUTO_CLEAR) begin
               sr_clr  = 1'b1;
               neg_d   = 1'b0;
               count_d = 2'd0;
               ovf_d   = 1'b0;
               state_d = EMPTY;
            end else begin
               state_d = (count_q == 2'd0) ? EMPTY : ENTRY;
            end
         end
      end else if (key_acc) begin
         if (is_digit(key_code)) begin
            // Leading zeros are swallowed so digit_count stays "significant digits".
            if (count_q == 2'(DIGITS)) begin
               ovf_d = 1'b1;
            end else if (!(key_code == 4'd0 && count_q == 2'd0)) begin
               sr_shl  = 1'b1;
               count_d = count_q + 2'd1;
               state_d = ENTRY;
            end
         end else begin
            case (key_code)
               KEY_SIGN: neg_d = ~neg_q;
               KEY_BKSP: begin
                  if (count_q != 2'd0) begin
                     sr_shr  = 1'b1;
                     count_d = count_q - 2'd1;
                     ovf_d   = 1'b0;
                     state_d = (count_q == 2'd1) ? EMPTY : ENTRY;
                  end
               end
               KEY_CLEAR: begin
                  sr_clr  = 1'b1;
                  neg_d   = 1'b0;
                  count_d = 2'd0;
                  ovf_d   = 1'b0;
                  state_d = EMPTY;
               end
               KEY_ENTER: begin
                  op_bcds_d = live_bcds_w;
                  op_neg_d  = neg_q;
                  op_vld_d  = 1'b1;
                  state_d   = HOLD;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         count_q   <= 2'd0;
         neg_q     <= 1'b0;
         ovf_q     <= 1'b0;
         op_bcds_q <= '0;
         op_neg_q  <= 1'b0;
         op_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         ovf_q     <= ovf_d;
         op_bcds_q <= op_bcds_d;
         op_neg_q  <= op_neg_d;
         op_vld_q  <= op_vld_d;
      end
   end

   assign key_ready     = (state_q != HOLD);
   assign live_bcds     = live_bcds_w;
   assign live_negative = neg_q;
   assign digit_count   = count_q;
   assign overflow      = ovf_q;
   assign op_bcds       = op_bcds_q;
   assign op_negative   = op_neg_q;
   assign op_valid      = op_vld_q;

endmodule

// File: tb/tb_bcd_entry.sv
// Bench for bcd_entry: directed key sequences on an AUTO_CLEAR=1 and an AUTO_CLEAR=0 instance,
// with handed-off operands checked by a scoreboard monitor.
module tb_bcd_entry;
   import calc_pkg::*;

   logic        clk;
   logic        rst_n;

   logic        k1_valid, k1_ready, neg1, ovf1, opn1, opv1, opr1;
   logic [3:0]  k1_code;
   logic [11:0] live1, op1;
   logic [1:0]  cnt1;

   logic        k2_valid, k2_ready, neg2, ovf2, opn2, opv2, opr2;
   logic [3:0]  k2_code;
   logic [11:0] live2, op2;
   logic [1:0]  cnt2;

   int tests;
   int fails;

   logic [12:0] q1[$];
   logic [12:0] q2[$];

   bcd_entry #(.DIGITS(3), .AUTO_CLEAR(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .key_valid(k1_valid), .key_code(k1_code), .key_ready(k1_ready),
      .live_bcds(live1), .live_negative(neg1), .digit_count(cnt1), .overflow(ovf1),
      .op_bcds(op1), .op_negative(opn1), .op_valid(opv1), .op_ready(opr1)
   );

   bcd_entry #(.DIGITS(3), .AUTO_CLEAR(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .key_valid(k2_valid), .key_code(k2_code), .key_ready(k2_ready),
      .live_bcds(live2), .live_negative(neg2), .digit_count(cnt2), .overflow(ovf2),
      .op_bcds(op2), .op_negative(opn2), .op_valid(opv2), .op_ready(opr2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic press1(input logic [3:0] code);
      k1_valid = 1'b1;
      k1_code  = code;
      @(posedge clk);
      #1;
      k1_valid = 1'b0;
   endtask

   task automatic press2(input logic [3:0] code);
      k2_valid = 1'b1;
      k2_code  = code;
      @(posedge clk);
      #1;
      k2_valid = 1'b0;
   endtask

   // Scoreboard monitor: a handshake seen between edges is consumed on the next rising edge.
   initial begin
      logic [12:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && opv1 && opr1) begin
            if (q1.size() == 0) chk("dut1 unexpected handoff", {opn1, op1}, 32'hFFFF);
            else begin
               e = q1.pop_front();
               chk("dut1 handoff {neg,bcds}", {opn1, op1}, e);
            end
         end
         if (rst_n && opv2 && opr2) begin
            if (q2.size() == 0) chk("dut2 unexpected handoff", {opn2, op2}, 32'hFFFF);
            else begin
               e = q2.pop_front();
               chk("dut2 handoff {neg,bcds}", {opn2, op2}, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      k1_valid = 1'b0; k1_code = 4'h0; opr1 = 1'b0;
      k2_valid = 1'b0; k2_code = 4'h0; opr2 = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset values
      chk("reset live_bcds", live1, 0);
      chk("reset live_negative", neg1, 0);
      chk("reset digit_count", cnt1, 0);
      chk("reset overflow", ovf1, 0);
      chk("reset op_bcds", op1, 0);
      chk("reset op_negative", opn1, 0);
      chk("reset op_valid", opv1, 0);
      chk("reset key_ready", k1_ready, 1);

      // 1: fill then overflow
      press1(4'd1); press1(4'd2); press1(4'd3);
      chk("t1 live 123", live1, 12'h123);
      chk("t1 count 3", cnt1, 3);
      chk("t1 overflow 0", ovf1, 0);
      press1(4'd4);
      chk("t1 live after 4th", live1, 12'h123);
      chk("t1 overflow set", ovf1, 1);
      press1(KEY_CLEAR);
      chk("t1 clear live", live1, 0);
      chk("t1 clear overflow", ovf1, 0);
      chk("t1 clear count", cnt1, 0);

      // 2: leading zeros, backspace to empty, backspace in empty
      press1(4'd0); press1(4'd0);
      chk("t2 leading zeros count", cnt1, 0);
      press1(4'd7);
      chk("t2 live 007", live1, 12'h007);
      chk("t2 count 1", cnt1, 1);
      press1(KEY_BKSP);
      chk("t2 bksp live", live1, 0);
      chk("t2 bksp count", cnt1, 0);
      press1(KEY_SIGN);
      press1(KEY_BKSP);
      chk("t2 bksp empty live", live1, 0);
      chk("t2 bksp empty count", cnt1, 0);
      chk("t2 bksp empty sign kept", neg1, 1);
      press1(KEY_SIGN);
      press1(4'hE);
      chk("t2 reserved ignored", {neg1, cnt1, live1}, 0);

      // 3: signed operand held under backpressure, then accepted
      press1(4'd4); press1(4'd5); press1(KEY_SIGN);
      chk("t3 live 045", live1, 12'h045);
      chk("t3 neg", neg1, 1);
      q1.push_back({1'b1, 12'h045});
      press1(KEY_ENTER);
      for (int i = 0; i < 5; i++) begin
         chk("t3 hold op_valid", opv1, 1);
         chk("t3 hold op {neg,bcds}", {opn1, op1}, {1'b1, 12'h045});
         chk("t3 hold key_ready", k1_ready, 0);
         @(posedge clk);
         #1;
      end
      press1(4'd7);
      chk("t3 dropped digit live", live1, 12'h045);
      chk("t3 dropped digit count", cnt1, 2);
      opr1 = 1'b1;
      @(posedge clk);
      #1;
      opr1 = 1'b0;
      chk("t3 op_valid after accept", opv1, 0);
      chk("t3 auto-clear live", {neg1, cnt1, live1}, 0);
      chk("t3 key_ready after accept", k1_ready, 1);

      // 4: ENTER in EMPTY sends zero
      q1.push_back(13'h0000);
      press1(KEY_ENTER);
      chk("t4 op_valid", opv1, 1);
      chk("t4 op {neg,bcds}", {opn1, op1}, 0);
      opr1 = 1'b1;
      @(posedge clk);
      #1;
      opr1 = 1'b0;
      chk("t4 op_valid after accept", opv1, 0);

      // 5: reset during HOLD, no handoff expected
      press1(4'd9); press1(4'd9); press1(4'd9); press1(KEY_ENTER);
      chk("t5 op_valid before reset", opv1, 1);
      chk("t5 op_bcds 999", op1, 12'h999);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t5 async op_valid", opv1, 0);
      chk("t5 async op_bcds", op1, 0);
      chk("t5 async live", {neg1, cnt1, ovf1, live1}, 0);
      chk("t5 async key_ready", k1_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("t5 after reset op_valid", opv1, 0);

      // 6: AUTO_CLEAR = 0 keeps the live entry
      press2(4'd6); press2(4'd2);
      q2.push_back({1'b0, 12'h062});
      press2(KEY_ENTER);
      chk("t6 op_valid", opv2, 1);
      opr2 = 1'b1;
      @(posedge clk);
      #1;
      opr2 = 1'b0;
      chk("t6 op_valid after accept", opv2, 0);
      chk("t6 live kept", live2, 12'h062);
      chk("t6 count kept", cnt2, 2);
      chk("t6 key_ready", k2_ready, 1);
      press2(4'd1);
      chk("t6 live 621", live2, 12'h621);
      chk("t6 count 3", cnt2, 3);

      repeat (2) @(posedge clk);
      #1;
      chk("dut1 scoreboard drained", q1.size(), 0);
      chk("dut2 scoreboard drained", q2.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
